key_drive: RTL and testbench

Debounced push-button input block: the input-side counterpart of the LED driver. It synchronises `P_KEY_NUMBER` raw key pins into `i_clk` and filters contact bounce on a millisecond time base. Per key it produces a debounced level plus single-cycle press, release and long-press event pulses. It sits between the board key pins and the user-logic control FSMs.

---
 rtl/key_pkg.sv | 13 +
 rtl/key_fsm.sv | 112 +++++++++++
 rtl/key_drive.sv | 52 +++++
 tb/tb_key_drive.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and counter width for the key debouncer
package key_pkg;

    localparam int MS_CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_RELEASE_DB
    } key_state_t;

endpackage

// File: rtl/key_fsm.sv
// rtl/key_fsm.sv - one key: 2-FF synchroniser, debounce FSM, press/release/long events
module key_fsm
    import key_pkg::*;
#(
    parameter int P_DEBOUNCE_MS = 20,
    parameter int P_LONG_MS     = 1000,
    parameter int P_KEY_ON      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic                ON_LEVEL   = (P_KEY_ON != 0);
    localparam logic [MS_CNT_W-1:0] DB_LIMIT   = MS_CNT_W'(P_DEBOUNCE_MS);
    localparam logic [MS_CNT_W-1:0] LONG_LIMIT = MS_CNT_W'(P_LONG_MS);

    logic                sync_a;
    logic                sync_b;
    logic                k_on;
    key_state_t          state;
    logic [MS_CNT_W-1:0] db_cnt;
    logic [MS_CNT_W-1:0] hold_cnt;
    logic [MS_CNT_W-1:0] db_inc;
    logic [MS_CNT_W-1:0] hold_inc;

    // Synchroniser starts at the released level so reset never looks like a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= ~ON_LEVEL;
            sync_b <= ~ON_LEVEL;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    assign k_on     = (sync_b == ON_LEVEL);
    assign db_inc   = db_cnt + 1'b1;
    assign hold_inc = hold_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            // Hold time keeps running through a release bounce; saturation gives one long pulse per press.
            if ((state == S_PRESSED || state == S_RELEASE_DB) && tick && hold_cnt != LONG_LIMIT) begin
                hold_cnt   <= hold_inc;
                long_pulse <= (hold_inc == LONG_LIMIT);
            end

            case (state)
                S_IDLE: begin
                    if (k_on) begin
                        state  <= S_PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                S_PRESS_DB: begin
                    if (!k_on) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (db_inc == DB_LIMIT) begin
                            state       <= S_PRESSED;
                            hold_cnt    <= '0;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                end
                S_PRESSED: begin
                    if (!k_on) begin
                        state  <= S_RELEASE_DB;
                        db_cnt <= '0;
                    end
                end
                S_RELEASE_DB: begin
                    if (k_on) begin
                        state <= S_PRESSED;
                    end else if (tick) begin
                        if (db_inc == DB_LIMIT) begin
                            state         <= S_IDLE;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_drive.sv
// rtl/key_drive.sv - shared 1 ms tick generator and per-key debouncer array
module key_drive #(
    parameter int P_KEY_NUMBER  = 1,
    parameter int P_TICK_DIV    = 50000,
    parameter int P_DEBOUNCE_MS = 20,
    parameter int P_LONG_MS     = 1000,
    parameter int P_KEY_ON      = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_KEY_NUMBER-1:0] i_key,
    output logic [P_KEY_NUMBER-1:0] o_key_level,
    output logic [P_KEY_NUMBER-1:0] o_key_press,
    output logic [P_KEY_NUMBER-1:0] o_key_release,
    output logic [P_KEY_NUMBER-1:0] o_key_long
);

    localparam int TW = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(P_TICK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < P_KEY_NUMBER; g++) begin : g_key
        key_fsm #(
            .P_DEBOUNCE_MS (P_DEBOUNCE_MS),
            .P_LONG_MS     (P_LONG_MS),
            .P_KEY_ON      (P_KEY_ON)
        ) u_key (
            .clk           (i_clk),
            .rst           (i_rst),
            .tick          (tick),
            .key           (i_key[g]),
            .level         (o_key_level[g]),
            .press_pulse   (o_key_press[g]),
            .release_pulse (o_key_release[g]),
            .long_pulse    (o_key_long[g])
        );
    end

endmodule

// File: tb/tb_key_drive.sv
// tb/tb_key_drive.sv - directed scoreboard bench for key_drive
module tb_key_drive;

    localparam int DIV  = 10;
    localparam int DEB  = 20;
    localparam int LONG = 100;
    localparam int EV_PRESS = 0;
    localparam int EV_LONG  = 1;
    localparam int EV_REL   = 2;

    typedef struct {
        int kind;
        int key;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] o_key_level;
    logic [1:0] o_key_press;
    logic [1:0] o_key_release;
    logic [1:0] o_key_long;

    int  cyc;
    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];

    key_drive #(
        .P_KEY_NUMBER  (2),
        .P_TICK_DIV    (DIV),
        .P_DEBOUNCE_MS (DEB),
        .P_LONG_MS     (LONG),
        .P_KEY_ON      (0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key         (key),
        .o_key_level   (o_key_level),
        .o_key_press   (o_key_press),
        .o_key_release (o_key_release),
        .o_key_long    (o_key_long)
    );

    always #5 clk = ~clk;

    // Edge counter restarts with the DUT so ticks land on edges that are multiples of DIV.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int kind, input int k, input int c);
        return {8'(kind), 8'(k), 16'(c)};
    endfunction

    // Edge at or after which a change driven just after edge n is accepted.
    function automatic int accept_at(input int n);
        int first_tick;
        first_tick = ((n + 4 + DIV - 1) / DIV) * DIV;
        return first_tick + (DEB - 1) * DIV;
    endfunction

    task automatic expect_ev(input int kind, input int k, input int c);
        ev_t e;
        e.kind = kind;
        e.key  = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic log_event(input int kind, input int k);
        ev_t e;
        if (sb.size() == 0) begin
            check("spurious_event", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("event", pack(kind, k, cyc), pack(e.kind, e.key, e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (o_key_press[k])   log_event(EV_PRESS, k);
                if (o_key_long[k])    log_event(EV_LONG, k);
                if (o_key_release[k]) log_event(EV_REL, k);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_key(input int idx, input logic v, output int n);
        @(posedge clk);
        #1;
        key[idx] = v;
        n = cyc;
    endtask

    task automatic set_keys(input logic [1:0] v, output int n);
        @(posedge clk);
        #1;
        key = v;
        n = cyc;
    endtask

    initial begin
        int n, m, g, p, r;

        // Reset state
        rst = 1'b1;
        key = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_key_level, o_key_press, o_key_release, o_key_long}, 8'h00);
        rst = 1'b0;
        wait_cyc(20);
        check("idle_level", o_key_level, 2'b00);

        // Clean press with long hold
        set_key(0, 1'b0, n);
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        expect_ev(EV_LONG, 0, p + LONG * DIV);
        wait_cyc(p - 1);
        check("clean_level_before", o_key_level, 2'b00);
        wait_cyc(p);
        check("clean_level_at_press", o_key_level, 2'b01);
        wait_cyc(n + 2999);
        set_key(0, 1'b1, m);
        r = accept_at(m);
        expect_ev(EV_REL, 0, r);
        wait_cyc(r - 1);
        check("clean_level_before_rel", o_key_level, 2'b01);
        wait_cyc(r);
        check("clean_level_after_rel", o_key_level, 2'b00);
        wait_cyc(r + 20);
        check("clean_sb_empty", sb.size(), 0);

        // Bounce: 30-cycle alternating phases, ends held low
        set_key(0, 1'b0, n);
        for (int i = 1; i < 5; i++) begin
            wait_cyc(n + 29);
            set_key(0, (i % 2 == 1) ? 1'b1 : 1'b0, n);
        end
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        wait_cyc(p - 1);
        check("bounce_level_before", o_key_level, 2'b00);
        wait_cyc(n + 400);
        check("bounce_level_held", o_key_level, 2'b01);
        set_key(0, 1'b1, m);
        r = accept_at(m);
        expect_ev(EV_REL, 0, r);
        wait_cyc(r + 10);
        check("bounce_sb_empty", sb.size(), 0);

        // Short press: no long pulse
        set_key(0, 1'b0, n);
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        wait_cyc(n + 499);
        set_key(0, 1'b1, m);
        expect_ev(EV_REL, 0, accept_at(m));
        wait_cyc(p + LONG * DIV + 100);
        check("short_sb_empty", sb.size(), 0);
        check("short_level", o_key_level, 2'b00);

        // Release glitch at tick 60 after press
        set_key(0, 1'b0, n);
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        expect_ev(EV_LONG, 0, p + LONG * DIV);
        wait_cyc(p + 599);
        set_key(0, 1'b1, g);
        wait_cyc(g + 49);
        set_key(0, 1'b0, g);
        wait_cyc(p + 1100);
        check("glitch_level", o_key_level, 2'b01);
        check("glitch_sb_empty", sb.size(), 0);
        set_key(0, 1'b1, m);
        r = accept_at(m);
        expect_ev(EV_REL, 0, r);
        wait_cyc(r + 5);
        check("glitch_level_after", o_key_level, 2'b00);

        // Reset while pressed
        set_key(0, 1'b0, n);
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        wait_cyc(p + 300);
        check("rstmid_level_before", o_key_level, 2'b01);
        check("rstmid_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_outputs", {o_key_level, o_key_press, o_key_release, o_key_long}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        p = accept_at(0);
        expect_ev(EV_PRESS, 0, p);
        wait_cyc(p - 1);
        check("rstmid_level_wait", o_key_level, 2'b00);
        wait_cyc(p);
        check("rstmid_level_repress", o_key_level, 2'b01);
        set_key(0, 1'b1, m);
        r = accept_at(m);
        expect_ev(EV_REL, 0, r);
        wait_cyc(r + 5);

        // Independence: both keys on the same cycle
        set_keys(2'b00, n);
        p = accept_at(n);
        expect_ev(EV_PRESS, 0, p);
        expect_ev(EV_PRESS, 1, p);
        wait_cyc(p);
        check("both_level", o_key_level, 2'b11);
        wait_cyc(p + 300);
        set_keys(2'b11, m);
        r = accept_at(m);
        expect_ev(EV_REL, 0, r);
        expect_ev(EV_REL, 1, r);
        wait_cyc(r + 5);
        check("both_level_after", o_key_level, 2'b00);
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
